// File: rtl/add_serial_nbit.sv
// Digit-serial WIDTH-bit add/subtract: DIGIT bits per clock, LSB digit first, valid/ready in and out.
// Optional macro ADD_SERIAL_FLAGS_EN adds the cout/ovf result flags.
`timescale 1ns/1ps

module add_serial_nbit #(
  parameter int WIDTH     = 32,
  parameter int DIGIT     = 1,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             busy
`ifdef ADD_SERIAL_FLAGS_EN
  ,
  output logic             cout,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG) + 1;

  generate
    if (WIDTH % DIGIT != 0) begin : g_param_err
      $error("add_serial_nbit: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and neither depends on the other side.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] d_sum;
  logic             d_cout;
  logic             last_digit;

  assign last_digit = (cnt == CW'(NDIG - 1));

  // Per-digit adder; IMPL_TYPE picks a behavioural or an explicit ripple-carry form.
  generate
    if (IMPL_TYPE == 0) begin : g_digit_behav
      assign {d_cout, d_sum} = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
                               + {{DIGIT{1'b0}}, carry};
    end else begin : g_digit_ripple
      logic [DIGIT:0] c;
      always_comb begin
        c     = '0;
        d_sum = '0;
        c[0]  = carry;
        for (int i = 0; i < DIGIT; i++) begin
          d_sum[i] = a_sr[i] ^ b_sr[i] ^ c[i];
          c[i+1]   = (a_sr[i] & b_sr[i]) | (c[i] & (a_sr[i] ^ b_sr[i]));
        end
      end
      assign d_cout = c[DIGIT];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = RUN;
      RUN:     if (last_digit) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN:  busy     = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted on load and the +1 enters as the initial carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= A;
            b_sr  <= B ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= (res_sr >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));
          carry  <= d_cout;
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign Sum = res_sr;

`ifdef ADD_SERIAL_FLAGS_EN
  logic c_msb;

  // Carry into the word MSB, recovered from the top bit of the last digit.
  assign c_msb = d_sum[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == RUN && last_digit) begin
      cout <= d_cout;
      ovf  <= d_cout ^ c_msb;
    end
  end
`endif

endmodule
